hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core (IF, DEC, EX, MEM, WB). It drives the stall and flush controls of the IF stage and of pipe0, pipe1 and pipe2. It handles three cases:
- load-use hazards;
- taken branches and jumps resolved in EX;
- a multi-cycle multiply that holds EX for MUL_LAT cycles.

It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_if.sv | 38 +++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Pipeline hazard signals: master is the pipeline side providing stage info,
// slave is the hazard controller returning stall/flush controls.
interface hazard_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       RsAddrD;
   logic [4:0]       RtAddrD;
   logic             UsesRtD;
   logic             MemReadE;
   logic             RegWriteE;
   logic [4:0]       RAddrE;
   logic             MULOpE;
   logic             BranchTakenE;
   logic             CountClear;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             FlushD;
   logic             FlushE;
   logic             FlushM;
   logic             MulBusy;
   logic             MulDone;
   logic [CNT_W-1:0] StallCycles;

   modport master (
      output RsAddrD, RtAddrD, UsesRtD, MemReadE, RegWriteE, RAddrE,
             MULOpE, BranchTakenE, CountClear,
      input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
             MulBusy, MulDone, StallCycles
   );

   modport slave (
      input  RsAddrD, RtAddrD, UsesRtD, MemReadE, RegWriteE, RAddrE,
             MULOpE, BranchTakenE, CountClear,
      output StallF, StallD, StallE, FlushD, FlushE, FlushM,
             MulBusy, MulDone, StallCycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage core: load-use, taken branch,
// multi-cycle multiply, plus a saturating stall-cycle counter.
//
//  state    | meaning
//  RUN      | normal issue; branch > multiply > load-use priority
//  MUL_BUSY | multiply holding EX; front end stalled until MulCnt reaches 0
module hazard_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 16
) (
   input logic   clk,
   input logic   rst,
   hazard_if.slave bus
);
   typedef enum logic {
      RUN      = 1'b0,
      MUL_BUSY = 1'b1
   } state_t;

   localparam logic [3:0]       MUL_INIT = 4'(MUL_LAT - 2);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state_q, state_d;
   logic [3:0]       mul_cnt_q, mul_cnt_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic load_use;
   logic stall_f, stall_d, stall_e;
   logic flush_d, flush_e, flush_m;
   logic mul_busy, mul_done;

   assign load_use = bus.MemReadE && bus.RegWriteE && (bus.RAddrE != 5'd0) &&
                     ((bus.RAddrE == bus.RsAddrD) ||
                      (bus.UsesRtD && (bus.RAddrE == bus.RtAddrD)));

   always_comb begin
      state_d        = state_q;
      mul_cnt_d      = mul_cnt_q;
      stall_cycles_d = stall_cycles_q;
      stall_f        = 1'b0;
      stall_d        = 1'b0;
      stall_e        = 1'b0;
      flush_d        = 1'b0;
      flush_e        = 1'b0;
      flush_m        = 1'b0;
      mul_busy       = 1'b0;
      mul_done       = 1'b0;
      // Outputs are forced quiet while reset is asserted, independent of the clock.
      if (!rst) begin
         case (state_q)
            MUL_BUSY: begin
               mul_busy = 1'b1;
               stall_f  = 1'b1;
               stall_d  = 1'b1;
               if (mul_cnt_q != 4'd0) begin
                  stall_e   = 1'b1;
                  flush_m   = 1'b1;
                  mul_cnt_d = mul_cnt_q - 4'd1;
               end else begin
                  mul_done = 1'b1;
                  state_d  = RUN;
               end
            end
            default: begin
               if (bus.BranchTakenE) begin
                  flush_d = 1'b1;
                  flush_e = 1'b1;
               end else if (bus.MULOpE) begin
                  stall_f   = 1'b1;
                  stall_d   = 1'b1;
                  stall_e   = 1'b1;
                  flush_m   = 1'b1;
                  state_d   = MUL_BUSY;
                  mul_cnt_d = MUL_INIT;
               end else if (load_use) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  flush_e = 1'b1;
               end
            end
         endcase

         if (bus.CountClear) begin
            stall_cycles_d = '0;
         end else if (stall_f && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= RUN;
         mul_cnt_q      <= 4'd0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         mul_cnt_q      <= mul_cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign bus.StallF      = stall_f;
   assign bus.StallD      = stall_d;
   assign bus.StallE      = stall_e;
   assign bus.FlushD      = flush_d;
   assign bus.FlushE      = flush_e;
   assign bus.FlushM      = flush_m;
   assign bus.MulBusy     = mul_busy;
   assign bus.MulDone     = mul_done;
   assign bus.StallCycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: cycle-by-cycle model comparison plus directed literal checks.
module tb_hazard_ctrl;
   localparam int MUL_LAT = 4;
   localparam int CNT_W   = 4;
   localparam int SAT     = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   hazard_if #(.CNT_W(CNT_W)) b ();

   hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: m_age = cycles the current multiply has already spent in EX (0 = none).
   int m_age = 0, m_cnt = 0, n_age = 0, n_cnt = 0;

   always @(negedge clk) begin
      logic lu, sf, sd, se, fd, fe, fm, busy, done;
      lu = b.MemReadE && b.RegWriteE && (b.RAddrE != 0) &&
           ((b.RAddrE == b.RsAddrD) || (b.UsesRtD && (b.RAddrE == b.RtAddrD)));
      {sf, sd, se, fd, fe, fm, busy, done} = '0;
      n_age = m_age;
      n_cnt = m_cnt;
      if (!rst) begin
         if (m_age > 0) begin
            busy = 1; sf = 1; sd = 1;
            if (m_age == MUL_LAT - 1) begin
               done = 1; n_age = 0;
            end else begin
               se = 1; fm = 1; n_age = m_age + 1;
            end
         end else if (b.BranchTakenE) begin
            fd = 1; fe = 1;
         end else if (b.MULOpE) begin
            sf = 1; sd = 1; se = 1; fm = 1; n_age = 1;
         end else if (lu) begin
            sf = 1; sd = 1; fe = 1;
         end
         if (b.CountClear) n_cnt = 0;
         else if (sf) n_cnt = (m_cnt + 1 > SAT) ? SAT : m_cnt + 1;
      end
      chk("m_StallF",  32'(b.StallF),  32'(sf));
      chk("m_StallD",  32'(b.StallD),  32'(sd));
      chk("m_StallE",  32'(b.StallE),  32'(se));
      chk("m_FlushD",  32'(b.FlushD),  32'(fd));
      chk("m_FlushE",  32'(b.FlushE),  32'(fe));
      chk("m_FlushM",  32'(b.FlushM),  32'(fm));
      chk("m_MulBusy", 32'(b.MulBusy), 32'(busy));
      chk("m_MulDone", 32'(b.MulDone), 32'(done));
      chk("m_Count",   32'(b.StallCycles), 32'(m_cnt));
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_age = 0;
         m_cnt = 0;
      end else begin
         m_age = n_age;
         m_cnt = n_cnt;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b.RsAddrD = 0; b.RtAddrD = 0; b.UsesRtD = 0; b.MemReadE = 0;
      b.RegWriteE = 0; b.RAddrE = 0; b.MULOpE = 0; b.BranchTakenE = 0;
      b.CountClear = 0;
   endtask

   task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses_rt);
      b.MemReadE = 1; b.RegWriteE = 1; b.RAddrE = rd;
      b.RsAddrD = rs; b.RtAddrD = rt; b.UsesRtD = uses_rt;
   endtask

   initial begin
      idle();
      // reset: hazard inputs active but every output must stay 0
      set_lu(5'd5, 5'd5, 5'd0, 1'b0);
      b.MULOpE = 1;
      repeat (2) cyc();
      chk("rst_StallF", 32'(b.StallF), 32'd0);
      chk("rst_StallE", 32'(b.StallE), 32'd0);
      chk("rst_MulBusy", 32'(b.MulBusy), 32'd0);
      chk("rst_Count", 32'(b.StallCycles), 32'd0);
      idle();
      rst = 0;
      cyc();

      // load-use on Rs
      set_lu(5'd5, 5'd5, 5'd0, 1'b0);
      #1 chk("lu_StallF", 32'(b.StallF), 32'd1);
      chk("lu_FlushE", 32'(b.FlushE), 32'd1);
      chk("lu_StallE", 32'(b.StallE), 32'd0);
      cyc();
      idle();
      #1 chk("lu_after", 32'(b.StallF), 32'd0);
      chk("lu_Count", 32'(b.StallCycles), 32'd1);
      set_lu(5'd0, 5'd0, 5'd0, 1'b0);
      #1 chk("lu_r0", 32'(b.StallF), 32'd0);
      cyc();

      // Rt gating
      idle();
      set_lu(5'd7, 5'd3, 5'd7, 1'b0);
      #1 chk("rt_unused", 32'(b.StallF), 32'd0);
      b.UsesRtD = 1;
      #1 chk("rt_used", 32'(b.StallF), 32'd1);
      chk("rt_StallD", 32'(b.StallD), 32'd1);
      cyc();
      idle();
      #1 chk("rt_Count", 32'(b.StallCycles), 32'd2);

      // branch beats load-use
      set_lu(5'd5, 5'd5, 5'd0, 1'b0);
      b.BranchTakenE = 1;
      #1 chk("br_FlushD", 32'(b.FlushD), 32'd1);
      chk("br_FlushE", 32'(b.FlushE), 32'd1);
      chk("br_StallF", 32'(b.StallF), 32'd0);
      cyc();
      idle();
      #1 chk("br_Count", 32'(b.StallCycles), 32'd2);

      // single multiply
      b.CountClear = 1;
      cyc();
      b.CountClear = 0;
      #1 chk("clr_Count", 32'(b.StallCycles), 32'd0);
      for (int i = 0; i < 5; i++) begin
         b.MULOpE = (i < 4);
         #1;
         chk("mul_StallE",  32'(b.StallE),  32'(i < 3));
         chk("mul_MulDone", 32'(b.MulDone), 32'(i == 3));
         chk("mul_StallF",  32'(b.StallF),  32'(i < 4));
         chk("mul_FlushM",  32'(b.FlushM),  32'(i < 3));
         chk("mul_MulBusy", 32'(b.MulBusy), 32'(i >= 1 && i <= 3));
         if (i == 4) chk("mul_Count", 32'(b.StallCycles), 32'd4);
         cyc();
      end

      // back-to-back multiplies: MULOpE stays high across both
      for (int i = 0; i < 9; i++) begin
         b.MULOpE = (i < 8);
         #1;
         chk("b2b_MulDone", 32'(b.MulDone), 32'(i == 3 || i == 7));
         chk("b2b_MulBusy", 32'(b.MulBusy), 32'(i != 0 && i != 4 && i != 8));
         chk("b2b_StallF",  32'(b.StallF),  32'(i < 8));
         cyc();
      end

      // reset in cycle 1 of a multiply
      idle();
      b.MULOpE = 1;
      cyc();
      #2 rst = 1;
      #1 chk("rmul_StallF", 32'(b.StallF), 32'd0);
      chk("rmul_MulBusy", 32'(b.MulBusy), 32'd0);
      chk("rmul_StallE", 32'(b.StallE), 32'd0);
      chk("rmul_Count", 32'(b.StallCycles), 32'd0);
      cyc();
      b.MULOpE = 0;
      rst = 0;
      #1 chk("rmul_after_busy", 32'(b.MulBusy), 32'd0);
      chk("rmul_after_stall", 32'(b.StallF), 32'd0);
      repeat (4) cyc();

      // saturation and clear priority
      set_lu(5'd9, 5'd9, 5'd0, 1'b0);
      repeat (20) cyc();
      chk("sat_Count", 32'(b.StallCycles), 32'd15);
      b.CountClear = 1;
      #1 chk("sat_StallF", 32'(b.StallF), 32'd1);
      cyc();
      b.CountClear = 0;
      #1 chk("sat_clr", 32'(b.StallCycles), 32'd0);
      cyc();
      chk("sat_inc", 32'(b.StallCycles), 32'd1);
      idle();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
